// File: rtl/mul_pkg.sv
// Shared constants for the sequential Booth multiply-accumulate unit.
package mul_pkg;

  // Default operand width; A, B and Z are this wide, P is twice this wide.
  localparam int unsigned MUL_W = 16;

  // Iteration counter width: must represent 0..W.
  localparam int unsigned MUL_CNT_W = $clog2(MUL_W + 1);

  // FSM state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_ACC  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/seq_multiplier16_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// followed by an arithmetic right shift of {acc, mult, q(-1)}.
module booth_step #(
  parameter int unsigned W = 16
) (
  input  logic [W:0]   acc_i,
  input  logic [W-1:0] mult_i,
  input  logic         qm1_i,
  input  logic [W:0]   m_i,
  output logic [W:0]   acc_o,
  output logic [W-1:0] mult_o,
  output logic         qm1_o
);

  logic [W:0] sum;

  // Booth recode on {q0, q(-1)}, then shift the combined register right by one.
  always_comb begin
    sum = acc_i;
    case ({mult_i[0], qm1_i})
      2'b10:   sum = acc_i - m_i;
      2'b01:   sum = acc_i + m_i;
      default: sum = acc_i;
    endcase
    acc_o  = {sum[W], sum[W:1]};
    mult_o = {sum[0], mult_i[W-1:1]};
    qm1_o  = mult_i[0];
  end

endmodule

// File: rtl/seq_multiplier16.sv
// Sequential signed multiply-accumulate P = A*B + Z using radix-2 Booth,
// one multiplier bit per clock, with a start/finish handshake.
module seq_multiplier16
  import mul_pkg::*;
#(
  parameter int unsigned W = MUL_W
) (
  input  logic           C,
  input  logic           RST,
  input  logic           S,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic [W-1:0]   Z,
  output logic [2*W-1:0] P,
  output logic           F,
  output logic           BSY
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [1:0]     state_q, state_d;
  logic [W:0]     m_q, m_d;
  logic [W:0]     acc_q, acc_d;
  logic [W-1:0]   mult_q, mult_d;
  logic [W-1:0]   z_q, z_d;
  logic           qm1_q, qm1_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] p_q, p_d;
  logic           f_q, f_d;
  logic           bsy_q, bsy_d;

  logic [W:0]     step_acc;
  logic [W-1:0]   step_mult;
  logic           step_qm1;

  booth_step #(.W(W)) u_step (
    .acc_i  (acc_q),
    .mult_i (mult_q),
    .qm1_i  (qm1_q),
    .m_i    (m_q),
    .acc_o  (step_acc),
    .mult_o (step_mult),
    .qm1_o  (step_qm1)
  );

  // Next-state logic: FSM sequencing, operand capture, iteration and final add.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    mult_d  = mult_q;
    z_d     = z_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    f_d     = f_q;
    bsy_d   = bsy_q;
    case (state_q)
      ST_IDLE: begin
        if (S) begin
          m_d     = {A[W-1], A};
          mult_d  = B;
          z_d     = Z;
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          bsy_d   = 1'b1;
          f_d     = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d  = step_acc;
        mult_d = step_mult;
        qm1_d  = step_qm1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_d = ST_ACC;
      end
      ST_ACC: begin
        // Product lives in the low 2W bits of {acc, mult}; acc's extra guard bit is dropped.
        p_d     = {acc_q[W-1:0], mult_q} + {{W{z_q[W-1]}}, z_q};
        f_d     = 1'b1;
        bsy_d   = 1'b0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!S) begin
          f_d     = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge C or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      mult_q  <= '0;
      z_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
      f_q     <= 1'b0;
      bsy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      mult_q  <= mult_d;
      z_q     <= z_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      f_q     <= f_d;
      bsy_q   <= bsy_d;
    end
  end

  assign P   = p_q;
  assign F   = f_q;
  assign BSY = bsy_q;

endmodule
